matrix_load_seq: RTL and testbench

MATRIX_LOAD_SEQ -- requirements
Module: matrix_load_seq

---
 rtl/matrix_load_seq.sv | 95 +++++++++
 tb/tb_matrix_load_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_load_seq.sv
// matrix_load_seq: assembles two N x N matrices (x then y) from a serial
// row-major element stream and presents them to a downstream multiplier.
//
// Ports:
//   clk       - clock, all state updates on posedge
//   rst       - synchronous active-high reset
//   in_valid  - in_data carries a valid element
//   in_ready  - block accepts an element this cycle (combinational, gated by rst)
//   in_data   - element stream, M bits
//   x, y      - assembled matrices, element (i,j) at [M*(i*N+j) +: M]
//   out_valid - x and y complete and stable (registered, high exactly in FULL)
//   out_ack   - downstream consumed x/y; honoured only in FULL
module matrix_load_seq #(
  parameter int unsigned N = 3,
  parameter int unsigned M = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [M-1:0]     in_data,
  output logic [M*N*N-1:0] x,
  output logic [M*N*N-1:0] y,
  output logic             out_valid,
  input  logic             out_ack
);

  localparam int unsigned NE = N * N;
  // A single-element matrix still needs a 1-bit index register.
  localparam int unsigned IW = (NE > 1) ? $clog2(NE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;

  // Ready whenever loading; forced low during reset so no beat is lost.
  assign in_ready = ~rst & (state != FULL);

  // Load sequencer: index, matrix storage and out_valid in one registered process.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD_X;
      idx       <= '0;
      x         <= '0;
      y         <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_X: begin
          if (in_valid) begin
            x[M*32'(idx) +: M] <= in_data;
            if (idx == LAST_IDX) begin
              idx   <= '0;
              state <= LOAD_Y;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        LOAD_Y: begin
          if (in_valid) begin
            y[M*32'(idx) +: M] <= in_data;
            if (idx == LAST_IDX) begin
              idx       <= '0;
              state     <= FULL;
              out_valid <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        FULL: begin
          // Matrices are kept on ack; the next load overwrites them in place.
          if (out_ack) begin
            idx       <= '0;
            state     <= LOAD_X;
            out_valid <= 1'b0;
          end
        end
        default: begin
          idx       <= '0;
          state     <= LOAD_X;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_load_seq.sv
// tb_matrix_load_seq: scoreboard bench for matrix_load_seq (N=3, M=32).
// The driver keeps a reference copy of x/y and pushes the expected pair when
// the final y beat is accepted; a monitor pops and compares on out_valid rise.
module tb_matrix_load_seq;

  localparam int unsigned N  = 3;
  localparam int unsigned M  = 32;
  localparam int unsigned NE = N * N;
  localparam int unsigned W  = M * NE;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] in_data;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         out_valid;
  logic         out_ack;

  matrix_load_seq #(.N(N), .M(M)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state.
  logic [W-1:0] mx;
  logic [W-1:0] my;
  int           m_idx;
  int           m_phase;   // 0 = x, 1 = y, 2 = full
  int           first_cyc;
  bit           gapped_run;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [M-1:0] el(input logic [W-1:0] mat, input int i, input int j);
    return mat[M*(i*N+j) +: M];
  endfunction

  task automatic model_clear();
    mx = '0;
    my = '0;
    m_idx = 0;
    m_phase = 0;
    sb.delete();
  endtask

  // One accepted beat; enters and leaves at posedge+1.
  task automatic send_beat(input logic [M-1:0] d, input logic ack);
    in_valid = 1'b1;
    in_data  = d;
    out_ack  = ack;
    @(negedge clk);
    chk("in_ready_load", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
    if (m_phase == 0 && m_idx == 0) first_cyc = cyc;
    if (m_phase == 0) mx[M*m_idx +: M] = d;
    else              my[M*m_idx +: M] = d;
    if (m_idx == NE - 1) begin
      m_idx = 0;
      if (m_phase == 1) begin
        exp_t e;
        e.x = mx;
        e.y = my;
        e.cyc = gapped_run ? -1 : first_cyc + 2*NE - 1;
        sb.push_back(e);
      end
      m_phase++;
    end else begin
      m_idx++;
    end
    in_valid = 1'b0;
    out_ack  = 1'b0;
  endtask

  task automatic load(input int base, input bit gapped, input bit stray_ack);
    gapped_run = gapped;
    for (int k = 0; k < 2*NE; k++) begin
      if (gapped) begin
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
      end
      send_beat(M'(base + k), stray_ack && (k % 4 == 1));
    end
  endtask

  task automatic drain(input string tag);
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
    chk(tag, W'(sb.size()), W'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    @(posedge clk);
    #1;
    out_ack = 1'b0;
    m_phase = 0;
    m_idx   = 0;
    @(negedge clk);
    chk("ack_out_valid", W'(out_valid), W'(0));
    chk("ack_in_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare popped expectation on each out_valid rising edge.
  bit ov_q = 1'b0;
  always @(negedge clk) begin
    if (!rst && out_valid && !ov_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", W'(out_valid), W'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_x", x, e.x);
        chk("sb_y", y, e.y);
        if (e.cyc >= 0) chk("sb_latency", W'(cyc), W'(e.cyc));
      end
    end
    ov_q = out_valid;
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h5;
    out_ack  = 1'b0;
    model_clear();

    // Reset held two cycles with in_valid asserted.
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_ready", W'(in_ready), W'(0));
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_x", x, '0);
      chk("rst_y", y, '0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", W'(in_ready), W'(1));
    chk("post_rst_out_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;

    // Continuous load 1..18.
    load(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("cont_out_valid", W'(out_valid), W'(1));
    chk("cont_in_ready", W'(in_ready), W'(0));
    chk("cont_x00", W'(el(x, 0, 0)), W'(1));
    chk("cont_x02", W'(el(x, 0, 2)), W'(3));
    chk("cont_x22", W'(el(x, 2, 2)), W'(9));
    chk("cont_y00", W'(el(y, 0, 0)), W'(10));
    chk("cont_y22", W'(el(y, 2, 2)), W'(18));
    drain("cont_drain");

    // FULL hold: input traffic must not disturb x/y.
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    repeat (5) begin
      @(negedge clk);
      chk("hold_x", x, mx);
      chk("hold_y", y, my);
      chk("hold_out_valid", W'(out_valid), W'(1));
      chk("hold_in_ready", W'(in_ready), W'(0));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;

    // Ack, then reload 101..118 with stray acks; old y survives early beats.
    ack();
    for (int k = 0; k < 3; k++) send_beat(M'(101 + k), k == 1);
    @(negedge clk);
    chk("partial_y22_kept", W'(el(y, 2, 2)), W'(18));
    chk("partial_x01", W'(el(x, 0, 1)), W'(102));
    chk("partial_out_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    gapped_run = 1'b1;
    for (int k = 3; k < 2*NE; k++) send_beat(M'(101 + k), (k % 4) == 1);
    @(negedge clk);
    chk("reload_x00", W'(el(x, 0, 0)), W'(101));
    chk("reload_y22", W'(el(y, 2, 2)), W'(118));
    drain("reload_drain");

    // Gapped load 1..18.
    ack();
    load(1, 1'b1, 1'b0);
    @(negedge clk);
    chk("gap_out_valid", W'(out_valid), W'(1));
    drain("gap_drain");

    // Mid-load reset after 5 beats, with valid and ack also asserted.
    ack();
    for (int k = 0; k < 5; k++) send_beat(M'(50 + k), 1'b0);
    rst      = 1'b1;
    in_valid = 1'b1;
    out_ack  = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", W'(in_ready), W'(0));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("midrst_x", x, '0);
    chk("midrst_y", y, '0);
    chk("midrst_out_valid", W'(out_valid), W'(0));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    out_ack  = 1'b0;
    model_clear();
    load(1, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_x00", W'(el(x, 0, 0)), W'(1));
    chk("midrst_y22", W'(el(y, 2, 2)), W'(18));
    drain("midrst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
